// File: rtl/display_pkg.sv
// Shared types and constants for the display scanner and its BCD converter.
package display_pkg;
  localparam int VALUE_W    = 14;
  localparam int NUM_DIGITS = 4;
  localparam int MAX_VALUE  = 9999;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [NUM_DIGITS-1:0] bcd4_t;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
endpackage

// File: rtl/display_scanner_if.sv
// Load handshake and scan outputs of the display scanner.
interface display_scanner_if;
  import display_pkg::*;
  logic [VALUE_W-1:0] value;
  logic               load;
  logic               busy;
  logic               overflow;
  logic [3:0]         digit;
  logic [3:0]         anode;

  modport master (output value, load, input busy, overflow, digit, anode);
  modport slave  (input value, load, output busy, overflow, digit, anode);
endinterface

// File: rtl/bcd_converter.sv
// Sequential double-dabble: 14 shift cycles then a one-cycle COMMIT strobe.
module bcd_converter
  import display_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [VALUE_W-1:0] i_value,
  output logic               o_busy,
  output logic               o_done,
  output bcd4_t              o_bcd,
  output logic               o_overflow
);
  state_t             r_state, w_state_nxt;
  logic [VALUE_W-1:0] r_bin, r_cap;
  logic [15:0]        r_bcd, w_adj;
  logic [3:0]         r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = CONV;
      CONV:    if (r_cnt == 4'(VALUE_W-1)) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_cap   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (i_start) begin
          r_bin <= i_value;
          r_cap <= i_value;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        CONV: begin
          // Adjusted BCD and binary shift as one 30-bit word.
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == COMMIT);
  assign o_bcd      = r_bcd;
  assign o_overflow = (r_cap > VALUE_W'(MAX_VALUE));
endmodule

// File: rtl/display_scanner.sv
// Binary-to-BCD display driver with free-running digit scan.
// Leading-zero blanking is enabled by defining DISPLAY_BLANK_EN.
module display_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  display_scanner_if.slave  bus
);
  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  bcd4_t           r_display;
  logic            r_overflow;
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [3:0]      r_digit, r_anode;
  logic            w_wrap;
  logic [NUM_DIGITS-1:0] w_blank;

  logic  w_busy, w_done, w_conv_ovf;
  bcd4_t w_bcd;

  bcd_converter u_conv (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (bus.load),
    .i_value   (bus.value),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_bcd     (w_bcd),
    .o_overflow(w_conv_ovf)
  );

  assign w_wrap    = (r_presc == PW'(REFRESH_DIV-1));
  assign w_idx_nxt = w_wrap ? r_idx + 2'd1 : r_idx;

`ifdef DISPLAY_BLANK_EN
  logic w_hi_zero;
  // A digit blanks only when it and everything above it is zero; units always lit.
  always_comb begin
    w_blank   = '0;
    w_hi_zero = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      w_hi_zero  = w_hi_zero && (r_display[i] == 4'd0);
      w_blank[i] = w_hi_zero;
    end
  end
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_display  <= '0;
      r_overflow <= 1'b0;
      r_presc    <= '0;
      r_idx      <= '0;
      r_digit    <= 4'd0;
      r_anode    <= 4'b1110;
    end else begin
      if (w_done) begin
        r_display  <= w_conv_ovf ? bcd4_t'({NUM_DIGITS{4'd9}}) : w_bcd;
        r_overflow <= w_conv_ovf;
      end
      r_presc <= w_wrap ? '0 : r_presc + PW'(1);
      r_idx   <= w_idx_nxt;
      // Outputs follow the next index so anode and index switch on the same edge.
      r_digit <= r_display[w_idx_nxt];
      r_anode <= w_blank[w_idx_nxt] ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
    end
  end

  assign bus.busy     = w_busy;
  assign bus.overflow = r_overflow;
  assign bus.digit    = r_digit;
  assign bus.anode    = r_anode;
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor checks them.
module tb_display_scanner;
  import display_pkg::*;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  display_scanner_if bus();
  display_scanner #(.REFRESH_DIV(DIV)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    string      name;
    bit         slot;
    bit         first;
    bit         chk_ovf;
    bit         chk_da;
    logic       busy;
    logic       ovf;
    logic [3:0] digit;
    logic [3:0] anode;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q[0];
        if (!e.slot || ((cyc % DIV) == 0 && (!e.first || ((cyc / DIV) % 4) == 0))) begin
          void'(q.pop_front());
          ok = 1'b1;
          if (!e.slot && bus.busy !== e.busy) ok = 1'b0;
          if (e.chk_ovf && bus.overflow !== e.ovf) ok = 1'b0;
          if (e.chk_da && (bus.digit !== e.digit || bus.anode !== e.anode)) ok = 1'b0;
          n_cmp++;
          if (!ok) begin
            n_err++;
            $display("FAIL %s: got busy=%b ovf=%b digit=%0d anode=%b, want busy=%b ovf=%b digit=%0d anode=%b",
                     e.name, bus.busy, bus.overflow, bus.digit, bus.anode,
                     e.busy, e.ovf, e.digit, e.anode);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_stat(input string name, input logic busy, input bit chk_ovf, input logic ovf);
    exp_t e;
    e = '{name: name, slot: 1'b0, first: 1'b0, chk_ovf: chk_ovf, chk_da: 1'b0,
          busy: busy, ovf: ovf, digit: 4'd0, anode: 4'd0};
    q.push_back(e);
  endtask

  task automatic push_rst(input string name);
    exp_t e;
    e = '{name: name, slot: 1'b0, first: 1'b0, chk_ovf: 1'b1, chk_da: 1'b1,
          busy: 1'b0, ovf: 1'b0, digit: 4'd0, anode: 4'b1110};
    q.push_back(e);
  endtask

  // Digits given thousands first, as written on the display.
  task automatic push_slots(input string name, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0, input logic ovf);
    exp_t       e;
    logic [3:0] d [4];
    logic [3:0] an;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < 4; i++) begin
      an = ~(4'b0001 << i);
`ifdef DISPLAY_BLANK_EN
      begin
        bit hz;
        hz = (i > 0);
        for (int j = i; j < 4; j++) if (d[j] != 4'd0) hz = 1'b0;
        if (hz) an = 4'b1111;
      end
`endif
      e = '{name: $sformatf("%s_slot%0d", name, i), slot: 1'b1, first: (i == 0), chk_ovf: 1'b1,
            chk_da: 1'b1, busy: 1'b0, ovf: ovf, digit: d[i], anode: an};
      q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending, want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic convert(input string name, input logic [13:0] v, input logic ovf,
                         input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0);
    bus.value = v;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    push_stat({name, "_busy_k"}, 1'b1, 1'b0, 1'b0);
    repeat (14) step();
    push_stat({name, "_busy_k14"}, 1'b1, 1'b0, 1'b0);
    step();
    push_stat({name, "_done"}, 1'b0, 1'b1, ovf);
    step();
    push_slots(name, d3, d2, d1, d0, ovf);
    wait_drain(name);
  endtask

  initial begin
    bus.value = '0;
    bus.load  = 1'b0;
    reset_n   = 1'b0;
    step();
    push_rst("reset");
    step();
    reset_n = 1'b1;
    push_slots("reset_scan", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_drain("reset_scan");

    convert("v1234",  14'd1234,  1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
    convert("v10000", 14'd10000, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
    convert("v5",     14'd5,     1'b0, 4'd0, 4'd0, 4'd0, 4'd5);
    convert("v9999",  14'd9999,  1'b0, 4'd9, 4'd9, 4'd9, 4'd9);
    convert("v7",     14'd7,     1'b0, 4'd0, 4'd0, 4'd0, 4'd7);
    convert("v0",     14'd0,     1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    convert("v16383", 14'd16383, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);

    // Load during conversion is dropped.
    bus.value = 14'd42;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    repeat (4) step();
    bus.value = 14'd777;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    push_stat("ign_busy", 1'b1, 1'b0, 1'b0);
    repeat (10) step();
    push_stat("ign_done", 1'b0, 1'b1, 1'b0);
    step();
    push_slots("ign777", 4'd0, 4'd0, 4'd4, 4'd2, 1'b0);
    wait_drain("ign777");

    // Load held high through COMMIT is re-accepted on the first IDLE edge.
    bus.value = 14'd8;
    bus.load  = 1'b1;
    step();
    repeat (15) step();
    push_stat("held_idle", 1'b0, 1'b1, 1'b0);
    step();
    bus.load  = 1'b0;
    push_stat("held_reaccept", 1'b1, 1'b0, 1'b0);
    repeat (15) step();
    push_stat("held_done", 1'b0, 1'b1, 1'b0);
    step();
    push_slots("held8", 4'd0, 4'd0, 4'd0, 4'd8, 1'b0);
    wait_drain("held8");

    // Reset mid-conversion discards the result and clears the display.
    bus.value = 14'd9999;
    bus.load  = 1'b1;
    step();
    bus.load  = 1'b0;
    repeat (6) step();
    reset_n = 1'b0;
    step();
    push_rst("midreset");
    reset_n = 1'b1;
    repeat (20) step();
    push_stat("midreset_idle", 1'b0, 1'b1, 1'b0);
    push_slots("midreset_scan", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_drain("midreset_scan");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
